if_id_inst_queue: RTL

- Consumer end of the instruction-fetch interface.
- Accepts {pc, instruction} pairs from the fetch stage into a small FIFO and presents them in order to the decode stage through a valid/ready handshake.
- Back-pressures fetch with `full`, which drives the fetch stage's freeze input.
- Discards all buffered instructions when `flush` is asserted; `flush` is the same branch_taken pulse that redirects fetch.

---
 rtl/arm_pipe_pkg.sv | 13 +
 rtl/queue_ptr.sv | 20 ++
 rtl/if_id_inst_queue.sv | 101 ++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared pipeline types and constants for the IF/ID boundary
package arm_pipe_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

   // pc/instruction pair carried between pipeline stages
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instruction;
   } pc_inst_t;

endpackage

// File: rtl/queue_ptr.sv
// rtl/queue_ptr.sv - wrapping queue pointer with increment and clear
module queue_ptr #(
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // pointer wraps naturally at 2**PTR_W; clear (flush) returns it to slot 0
   always_ff @(posedge clk) begin
      if (rst || clr)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/if_id_inst_queue.sv
// rtl/if_id_inst_queue.sv - fetch-to-decode instruction FIFO; IF_ID_QUEUE_STATS_EN adds flush_drop_count
module if_id_inst_queue
   import arm_pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   input  logic [XLEN-1:0] if_pc,
   input  logic [XLEN-1:0] if_instruction,
   output logic            full,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instruction
`ifdef IF_ID_QUEUE_STATS_EN
   ,
   output logic [15:0]     flush_drop_count
`endif
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   pc_inst_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push;
   logic             pop;
   pc_inst_t         head;

   // status comes from the registered count only, so freeze has no path from if_valid/id_ready
   assign full     = (count == FULL_CNT);
   assign id_valid = (count != '0);

   // a full queue refuses fetch even when decode drains this cycle; flush cancels both sides
   assign push = if_valid & ~full & ~flush;
   assign pop  = id_valid & id_ready & ~flush;

   queue_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (push),
      .ptr (wr_ptr)
   );

   queue_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (pop),
      .ptr (rd_ptr)
   );

   // storage write; contents are don't-care until count covers them
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{pc: if_pc, instruction: if_instruction};
   end

   // occupancy tracks push/pop; simultaneous push and pop leave it unchanged
   always_ff @(posedge clk) begin
      if (rst || flush)
         count <= '0;
      else if (push && !pop)
         count <= count + 1'b1;
      else if (pop && !push)
         count <= count - 1'b1;
   end

   assign head = mem[rd_ptr];

   // decode sees the head entry, or a NOP with pc 0 when the queue is empty
   always_comb begin
      id_pc          = '0;
      id_instruction = NOP_INSTR;
      if (id_valid) begin
         id_pc          = head.pc;
         id_instruction = head.instruction;
      end
   end

`ifdef IF_ID_QUEUE_STATS_EN
   logic [16:0] drop_sum;

   assign drop_sum = {1'b0, flush_drop_count} + 17'(count);

   // accumulate instructions thrown away by flushes, saturating at all-ones
   always_ff @(posedge clk) begin
      if (rst)
         flush_drop_count <= '0;
      else if (flush)
         flush_drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end
`endif

endmodule
